shoot_trigger_conditioner: RTL and testbench

//  Conditions the raw player fire key into the clean active-low shootN request consumed by the shot-enable

---
 rtl/shoot_trigger_conditioner_if.sv | 23 ++
 rtl/shoot_trigger_conditioner.sv | 128 ++++++++++++
 tb/tb_shoot_trigger_conditioner.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/shoot_trigger_conditioner_if.sv
// Fire-key request bus between the player input block and the shot-enable stage.
// The reloadN signal exists only when AMMO_RELOAD_EN is defined.
interface shoot_trigger_conditioner_if;
  logic       keyN;
  logic       fire_enable;
  logic       shootN;
  logic       shot_pulse;
  logic [3:0] ammo_left;
  logic       out_of_ammo;
`ifdef AMMO_RELOAD_EN
  logic       reloadN;

  modport master (output keyN, fire_enable, reloadN,
                  input  shootN, shot_pulse, ammo_left, out_of_ammo);
  modport slave  (input  keyN, fire_enable, reloadN,
                  output shootN, shot_pulse, ammo_left, out_of_ammo);
`else
  modport master (output keyN, fire_enable,
                  input  shootN, shot_pulse, ammo_left, out_of_ammo);
  modport slave  (input  keyN, fire_enable,
                  output shootN, shot_pulse, ammo_left, out_of_ammo);
`endif
endinterface

// File: rtl/shoot_trigger_conditioner.sv
// Synchronises/debounces the fire key into a fixed-width active-low shootN pulse with cooldown and ammo limit.
// Optional AMMO_RELOAD_EN adds a synchronous active-low reloadN that refills ammo outside DEBOUNCE/FIRE.
module shoot_trigger_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int FIRE_CYCLES     = 4,
  parameter int COOLDOWN_CYCLES = 5000000,
  parameter int MAX_AMMO        = 8
) (
  input  logic                          clk,
  input  logic                          resetN,
  shoot_trigger_conditioner_if.slave    bus
);

  localparam int CNT_MAX0 = (DEBOUNCE_CYCLES > FIRE_CYCLES) ? DEBOUNCE_CYCLES : FIRE_CYCLES;
  localparam int CNT_MAX  = (CNT_MAX0 > COOLDOWN_CYCLES) ? CNT_MAX0 : COOLDOWN_CYCLES;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_END  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] FIRE_END = CNT_W'(FIRE_CYCLES);
  localparam logic [CNT_W-1:0] COOL_END = CNT_W'(COOLDOWN_CYCLES);
  localparam logic [3:0]       AMMO_FULL = 4'(MAX_AMMO);

  localparam logic [2:0] IDLE         = 3'd0;
  localparam logic [2:0] DEBOUNCE     = 3'd1;
  localparam logic [2:0] FIRE         = 3'd2;
  localparam logic [2:0] COOLDOWN     = 3'd3;
  localparam logic [2:0] WAIT_RELEASE = 3'd4;

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             key_meta;
  logic             key_s;
  logic             shoot;
  logic             pulse;
  logic [3:0]       ammo;
  logic             empty;
  logic             reload;

`ifdef AMMO_RELOAD_EN
  assign reload = ~bus.reloadN;
`else
  assign reload = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      key_meta <= 1'b1;
      key_s    <= 1'b1;
    end else begin
      key_meta <= bus.keyN;
      key_s    <= key_meta;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
      cnt   <= '0;
      shoot <= 1'b1;
      pulse <= 1'b0;
      ammo  <= AMMO_FULL;
      empty <= 1'b0;
    end else begin
      pulse <= 1'b0;
      empty <= (ammo == '0);
      case (state)
        IDLE: begin
          if (!key_s && bus.fire_enable && ammo != '0) begin
            state <= DEBOUNCE;
            cnt   <= CNT_ONE;
          end
        end
        DEBOUNCE: begin
          if (key_s || !bus.fire_enable) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DEB_END) begin
            state <= FIRE;
            cnt   <= CNT_ONE;
            shoot <= 1'b0;
            pulse <= 1'b1;
            if (ammo != '0) ammo <= ammo - 4'd1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        FIRE: begin
          // fire_enable deliberately ignored so the pulse is never truncated
          if (cnt == FIRE_END) begin
            state <= COOLDOWN;
            cnt   <= CNT_ONE;
            shoot <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        COOLDOWN: begin
          if (cnt == COOL_END) begin
            state <= WAIT_RELEASE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        WAIT_RELEASE: begin
          if (key_s) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          shoot <= 1'b1;
        end
      endcase
      // Reload overrides the registered empty flag so both refill on the same edge
      if (reload && (state == IDLE || state == COOLDOWN || state == WAIT_RELEASE)) begin
        ammo  <= AMMO_FULL;
        empty <= 1'b0;
      end
    end
  end

  assign bus.shootN      = shoot;
  assign bus.shot_pulse  = pulse;
  assign bus.ammo_left   = ammo;
  assign bus.out_of_ammo = empty;

endmodule

// File: tb/tb_shoot_trigger_conditioner.sv
// Scoreboard bench: each accepted press queues its expected shootN fall edge and post-shot ammo.
// Covers AMMO_RELOAD_EN reload behaviour when that macro is defined.
module tb_shoot_trigger_conditioner;

  localparam int DEB  = 4;
  localparam int FIR  = 3;
  localparam int COOL = 10;
  localparam int AMMO = 8;

  typedef struct {
    int edge_no;
    int ammo;
  } shot_t;

  logic  clk = 1'b0;
  logic  resetN;
  int    cyc = 0;
  int    n_checks = 0;
  int    n_pass = 0;
  int    exp_ammo;
  shot_t scb[$];
  shot_t e;
  logic  prev_s = 1'b1;
  int    low_w = 0;

  shoot_trigger_conditioner_if sif ();

  shoot_trigger_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .FIRE_CYCLES    (FIR),
    .COOLDOWN_CYCLES(COOL),
    .MAX_AMMO       (AMMO)
  ) dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (sif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Monitor: pops the scoreboard on each shootN fall and measures the low width
  always @(negedge clk) begin
    if (resetN) begin
      if (prev_s && !sif.shootN) begin
        if (scb.size() == 0) begin
          check("unexpected_shot", cyc, -1);
        end else begin
          e = scb.pop_front();
          check("fall_edge", cyc, e.edge_no);
          check("ammo_at_shot", int'(sif.ammo_left), e.ammo);
          check("pulse_at_shot", int'(sif.shot_pulse), 1);
        end
        low_w <= 1;
      end else if (!sif.shootN) begin
        low_w <= low_w + 1;
      end else if (!prev_s) begin
        check("low_width", low_w, FIR);
      end
      if (sif.shot_pulse && !(prev_s && !sif.shootN)) check("stray_pulse", 1, 0);
      prev_s <= sif.shootN;
    end else begin
      prev_s <= 1'b1;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int hold);
    @(posedge clk); #1;
    sif.keyN = 1'b0;
    if (sif.fire_enable && exp_ammo > 0 && hold >= DEB + 1) begin
      scb.push_back('{cyc + 1 + 2 + DEB, exp_ammo - 1});
      exp_ammo--;
    end
    repeat (hold) @(posedge clk);
    #1 sif.keyN = 1'b1;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2;
    resetN = 1'b0;
    @(posedge clk); #1;
    resetN = 1'b1;
    exp_ammo = AMMO;
  endtask

  initial begin
    resetN          = 1'b0;
    sif.keyN        = 1'b1;
    sif.fire_enable = 1'b1;
`ifdef AMMO_RELOAD_EN
    sif.reloadN     = 1'b1;
`endif
    exp_ammo = AMMO;
    idle(3);
    check("rst_shootN", int'(sif.shootN), 1);
    check("rst_pulse", int'(sif.shot_pulse), 0);
    check("rst_ammo", int'(sif.ammo_left), AMMO);
    check("rst_empty", int'(sif.out_of_ammo), 0);
    resetN = 1'b1;
    idle(5);

    // Held key: exactly one shot
    press(40);
    idle(15);
    check("t1_pending", scb.size(), 0);
    check("t1_ammo", int'(sif.ammo_left), 7);

    // Bounce: neither low run is long enough
    @(posedge clk); #1 sif.keyN = 1'b0;
    idle(3); sif.keyN = 1'b1;
    idle(1); sif.keyN = 1'b0;
    idle(3); sif.keyN = 1'b1;
    idle(15);
    check("t2_ammo", int'(sif.ammo_left), 7);
    check("t2_shootN", int'(sif.shootN), 1);

    // fire_enable dropped during DEBOUNCE
    @(posedge clk); #1 sif.keyN = 1'b0;
    idle(4); sif.fire_enable = 1'b0;
    idle(10); sif.keyN = 1'b1;
    idle(3); sif.fire_enable = 1'b1;
    idle(5);
    check("t4a_ammo", int'(sif.ammo_left), 7);

    // fire_enable dropped during FIRE: pulse must still be full width
    @(posedge clk); #1 sif.keyN = 1'b0;
    scb.push_back('{cyc + 1 + 2 + DEB, exp_ammo - 1});
    exp_ammo--;
    idle(7); sif.fire_enable = 1'b0;
    idle(13); sif.keyN = 1'b1;
    idle(15); sif.fire_enable = 1'b1;
    idle(5);
    check("t4b_pending", scb.size(), 0);
    check("t4b_ammo", int'(sif.ammo_left), 6);

    // Async reset in the middle of FIRE
    @(posedge clk); #1 sif.keyN = 1'b0;
    scb.push_back('{cyc + 1 + 2 + DEB, exp_ammo - 1});
    exp_ammo--;
    idle(7);
    @(posedge clk); #2;
    resetN = 1'b0;
    sif.keyN = 1'b1;
    #1;
    check("t5_shootN", int'(sif.shootN), 1);
    check("t5_ammo", int'(sif.ammo_left), AMMO);
    check("t5_empty", int'(sif.out_of_ammo), 0);
    exp_ammo = AMMO;
    @(posedge clk); #1 resetN = 1'b1;
    idle(5);
    press(10);
    idle(25);
    check("t5_pending", scb.size(), 0);
    check("t5_after_ammo", int'(sif.ammo_left), 7);

    // Nine presses from a full magazine: only eight shots
    pulse_reset();
    idle(5);
    check("t3_start_ammo", int'(sif.ammo_left), AMMO);
    for (int i = 0; i < 9; i++) begin
      press(10);
      idle(20);
    end
    check("t3_pending", scb.size(), 0);
    check("t3_ammo", int'(sif.ammo_left), 0);
    check("t3_empty", int'(sif.out_of_ammo), 1);
    check("t3_shootN", int'(sif.shootN), 1);

`ifdef AMMO_RELOAD_EN
    @(posedge clk); #1 sif.reloadN = 1'b0;
    @(posedge clk); #1 sif.reloadN = 1'b1;
    check("t6_ammo", int'(sif.ammo_left), AMMO);
    check("t6_empty", int'(sif.out_of_ammo), 0);
    exp_ammo = AMMO;
    idle(3);
    press(10);
    idle(25);
    check("t6_pending", scb.size(), 0);
    check("t6_after_ammo", int'(sif.ammo_left), 7);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
